// File: rtl/store_rmw_sequencer_if.sv
// Bundles the store request, merge-stage and memory signals of the store RMW sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface store_rmw_sequencer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_done;
    logic        st_error;

    logic [31:0] mg_old_data;
    logic [31:0] mg_data;
    logic [2:0]  mg_funct3;
    logic [31:0] mg_result;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, mg_result, mem_rdata, mem_ack,
        output st_ready, st_done, st_error, mg_old_data, mg_data, mg_funct3,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output st_valid, st_addr, st_data, st_funct3, mg_result, mem_rdata, mem_ack,
        input  st_ready, st_done, st_error, mg_old_data, mg_data, mg_funct3,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_rmw_sequencer.sv
// Turns byte/half stores into read-modify-write transactions on a word-wide memory;
// word stores are written directly, illegal or misaligned stores are rejected.
module store_rmw_sequencer (
    input  logic                        clock,
    input  logic                        reset,
    store_rmw_sequencer_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;

    state_t      state;
    logic [4:0]  sh;
    logic [31:0] old_reg;
    logic [31:0] data_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] wdata_reg;
    logic [31:0] addr_reg;
    logic        ready_reg;
    logic        done_reg;
    logic        error_reg;
    logic        req_reg;
    logic        we_reg;

    function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_BYTE: return 1'b1;
            F3_HALF: return !lo[0];
            F3_WORD: return lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} >> s;
        return t[31:0];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    // Outputs come straight from state registers so nothing combinational reaches the ports.
    assign bus.st_ready    = ready_reg;
    assign bus.st_done     = done_reg;
    assign bus.st_error    = error_reg;
    assign bus.mem_req     = req_reg;
    assign bus.mem_we      = we_reg;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_wdata   = wdata_reg;
    assign bus.mg_old_data = old_reg;
    assign bus.mg_data     = data_reg;
    assign bus.mg_funct3   = funct3_reg;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            old_reg    <= '0;
            data_reg   <= '0;
            funct3_reg <= '0;
            wdata_reg  <= '0;
            addr_reg   <= '0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.st_valid) begin
                        ready_reg  <= 1'b0;
                        addr_reg   <= {bus.st_addr[31:2], 2'b00};
                        data_reg   <= bus.st_data;
                        funct3_reg <= bus.st_funct3;
                        sh         <= {bus.st_addr[1:0], 3'b000};
                        if (!is_legal(bus.st_funct3, bus.st_addr[1:0])) begin
                            state     <= DONE;
                            done_reg  <= 1'b1;
                            error_reg <= 1'b1;
                        end else if (bus.st_funct3 == F3_WORD) begin
                            state     <= WRITE;
                            wdata_reg <= bus.st_data;
                            req_reg   <= 1'b1;
                            we_reg    <= 1'b1;
                        end else begin
                            state   <= READ;
                            req_reg <= 1'b1;
                            we_reg  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (bus.mem_ack) begin
                        old_reg <= rotr(bus.mem_rdata, sh);
                        req_reg <= 1'b0;
                        state   <= MERGE;
                    end
                end
                // The external merge stage settles within this single cycle.
                MERGE: begin
                    wdata_reg <= rotl(bus.mg_result, sh);
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        req_reg  <= 1'b0;
                        we_reg   <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Directed bench for store_rmw_sequencer with a merge-stage model and a wait-state memory responder.
module tb_store_rmw_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;

    store_rmw_sequencer_if bus ();

    store_rmw_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder state and transaction log
    logic [31:0] mem_word;
    int          wait_cycles = 0;
    int          wait_cnt    = 0;
    int          rd_count, wr_count;
    logic [31:0] last_raddr, last_waddr, last_wdata;
    logic        req_seen;

    // Per-cycle snapshots, cycle 1 = first cycle after the acceptance edge
    logic        snap_req  [0:40];
    logic        snap_we   [0:40];
    logic [31:0] snap_addr [0:40];
    logic [31:0] snap_old  [0:40];

    // Reference model of the downstream store_data_size merge stage
    always_comb begin
        case (bus.mg_funct3)
            3'b000:  bus.mg_result = {bus.mg_old_data[31:8],  bus.mg_data[7:0]};
            3'b001:  bus.mg_result = {bus.mg_old_data[31:16], bus.mg_data[15:0]};
            default: bus.mg_result = bus.mg_data;
        endcase
    end

    always @(negedge clock) begin
        if (reset || !bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end else if (wait_cnt >= wait_cycles) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word;
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    always @(posedge clock) begin
        if (!reset && bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
                wr_count++;
                last_waddr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
            end else begin
                rd_count++;
                last_raddr = bus.mem_addr;
            end
        end
    end

    always @(posedge bus.mem_req) req_seen = 1'b1;

    task automatic clear_log();
        rd_count   = 0;
        wr_count   = 0;
        last_raddr = '0;
        last_waddr = '0;
        last_wdata = '0;
        req_seen   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        @(negedge clock);
        bus.st_valid  = 1'b1;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.st_funct3 = f3;
        @(posedge clock);
        #1 bus.st_valid = 1'b0;
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             output int done_cyc, output logic err);
        issue(a, d, f3);
        done_cyc = 0;
        err      = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            snap_req[c]  = bus.mem_req;
            snap_we[c]   = bus.mem_we;
            snap_addr[c] = bus.mem_addr;
            snap_old[c]  = bus.mg_old_data;
            if (bus.st_done) begin
                done_cyc = c;
                err      = bus.st_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.st_ready); end
        n_checks++;
        if ({bus.st_done, bus.st_error, bus.mem_req, bus.mem_we} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.st_done, bus.st_error, bus.mem_req, bus.mem_we});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mg_old_data, bus.mg_data, bus.mg_funct3} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h old %h data %h f3 %b want 0",
                               bus.mem_addr, bus.mem_wdata, bus.mg_old_data, bus.mg_data, bus.mg_funct3);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_byte();
        int dc; logic er;
        wait_cycles = 0; mem_word = 32'h1122_3344; clear_log();
        run_store(32'h102, 32'h0000_00AB, 3'b000, dc, er);
        n_checks++;
        if (dc !== 4 || er !== 1'b0) begin n_fail++; $display("FAIL byte_done: cycle %0d err %b want 4 / 0", dc, er); end
        n_checks++;
        if (rd_count !== 1 || last_raddr !== 32'h100) begin
            n_fail++; $display("FAIL byte_read: count %0d addr %h want 1 / 00000100", rd_count, last_raddr);
        end
        n_checks++;
        if (snap_req[1] !== 1'b1 || snap_we[1] !== 1'b0) begin
            n_fail++; $display("FAIL byte_read_cycle1: req %b we %b want 1 / 0", snap_req[1], snap_we[1]);
        end
        n_checks++;
        if (snap_old[2] !== 32'h3344_1122) begin n_fail++; $display("FAIL byte_mg_old: got %h want 33441122", snap_old[2]); end
        n_checks++;
        if (snap_req[3] !== 1'b1 || snap_we[3] !== 1'b1) begin
            n_fail++; $display("FAIL byte_write_cycle3: req %b we %b want 1 / 1", snap_req[3], snap_we[3]);
        end
        n_checks++;
        if (wr_count !== 1 || last_wdata !== 32'h11AB_3344 || last_waddr !== 32'h100) begin
            n_fail++; $display("FAIL byte_write: count %0d data %h addr %h want 1 / 11ab3344 / 00000100",
                               wr_count, last_wdata, last_waddr);
        end
        @(negedge clock);
        n_checks++;
        if (bus.st_ready !== 1'b1) begin n_fail++; $display("FAIL byte_ready_after: got %b want 1", bus.st_ready); end
    endtask

    task automatic test_half();
        int dc; logic er;
        wait_cycles = 0; mem_word = 32'hAAAA_AAAA; clear_log();
        run_store(32'h202, 32'h0000_BEEF, 3'b001, dc, er);
        n_checks++;
        if (dc !== 4 || er !== 1'b0) begin n_fail++; $display("FAIL half_done: cycle %0d err %b want 4 / 0", dc, er); end
        n_checks++;
        if (wr_count !== 1 || last_wdata !== 32'hBEEF_AAAA || last_waddr !== 32'h200) begin
            n_fail++; $display("FAIL half_write: count %0d data %h addr %h want 1 / beefaaaa / 00000200",
                               wr_count, last_wdata, last_waddr);
        end
    endtask

    task automatic test_word();
        int dc; logic er;
        wait_cycles = 0; mem_word = 32'h0; clear_log();
        run_store(32'h300, 32'hDEAD_BEEF, 3'b010, dc, er);
        n_checks++;
        if (dc !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL word_done: cycle %0d err %b want 2 / 0", dc, er); end
        n_checks++;
        if (rd_count !== 0 || wr_count !== 1 || last_wdata !== 32'hDEAD_BEEF || last_waddr !== 32'h300) begin
            n_fail++; $display("FAIL word_mem: reads %0d writes %0d data %h addr %h want 0 / 1 / deadbeef / 00000300",
                               rd_count, wr_count, last_wdata, last_waddr);
        end
    endtask

    task automatic test_reject();
        logic [31:0] addrs [3];
        logic [2:0]  f3s   [3];
        int dc; logic er;
        addrs = '{32'h101, 32'h302, 32'h400};
        f3s   = '{3'b001,  3'b010,  3'b011};
        for (int i = 0; i < 3; i++) begin
            clear_log();
            run_store(addrs[i], 32'h1234_5678, f3s[i], dc, er);
            n_checks++;
            if (dc !== 1 || er !== 1'b1) begin
                n_fail++; $display("FAIL reject_%0d_done: cycle %0d err %b want 1 / 1", i, dc, er);
            end
            n_checks++;
            if (req_seen !== 1'b0) begin n_fail++; $display("FAIL reject_%0d_mem: mem_req seen %b want 0", i, req_seen); end
        end
    endtask

    task automatic test_wait_states();
        int dc; logic er; logic stable;
        wait_cycles = 3; mem_word = 32'h1122_3344; clear_log();
        run_store(32'h102, 32'h0000_00AB, 3'b000, dc, er);
        n_checks++;
        if (dc !== 10 || er !== 1'b0) begin n_fail++; $display("FAIL wait_done: cycle %0d err %b want 10 / 0", dc, er); end
        stable = 1'b1;
        for (int c = 1; c <= 4; c++)
            if (snap_req[c] !== 1'b1 || snap_we[c] !== 1'b0 || snap_addr[c] !== 32'h100) stable = 1'b0;
        for (int c = 6; c <= 9; c++)
            if (snap_req[c] !== 1'b1 || snap_we[c] !== 1'b1 || snap_addr[c] !== 32'h100) stable = 1'b0;
        n_checks++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL wait_stable: req/we/addr held got %b want 1", stable); end
        n_checks++;
        if (rd_count !== 1 || wr_count !== 1 || last_wdata !== 32'h11AB_3344) begin
            n_fail++; $display("FAIL wait_mem: reads %0d writes %0d data %h want 1 / 1 / 11ab3344",
                               rd_count, wr_count, last_wdata);
        end
        wait_cycles = 0;
    endtask

    task automatic test_reset_mid_read();
        int dc; logic er; logic dn;
        wait_cycles = 5; mem_word = 32'h1122_3344; clear_log();
        issue(32'h102, 32'h0000_00AB, 3'b000);
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", bus.mem_req); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.st_ready !== 1'b1 || bus.mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_async: req %b ready %b addr %h want 0 / 1 / 00000000",
                               bus.mem_req, bus.st_ready, bus.mem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        dn = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (bus.st_done) dn = 1'b1;
        end
        n_checks++;
        if (dn !== 1'b0 || bus.st_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_no_done: done seen %b ready %b want 0 / 1", dn, bus.st_ready);
        end
        wait_cycles = 0; clear_log();
        run_store(32'h001, 32'h0000_0055, 3'b000, dc, er);
        n_checks++;
        if (dc !== 4 || er !== 1'b0 || last_wdata !== 32'h1122_5544 || last_waddr !== 32'h0) begin
            n_fail++; $display("FAIL rst_next_store: cycle %0d err %b data %h addr %h want 4 / 0 / 11225544 / 00000000",
                               dc, er, last_wdata, last_waddr);
        end
    endtask

    initial begin
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.st_funct3 = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        mem_word      = '0;
        clear_log();
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_reject();
        test_wait_states();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
